// File: rtl/uni_ctrl_mc_if.sv
// Control bus between the multicycle controller and its datapath/memory side.
// The controller takes the slave view: it receives the opcode and the memory
// handshake and drives every control strobe plus its state and retire count.
interface uni_ctrl_mc_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic [OP_W-1:0]    Op;
  logic               mem_ready;
  logic               PCWrite;
  logic               IRWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               MemToReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic               Branch;
  logic               BranchNE;
  logic               illegal;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         PCSource;
  logic [3:0]         state;
  logic [CNT_W-1:0]   retired;

  modport master (
    output Op, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst,
           RegWrite, ALUSrcA, Branch, BranchNE, illegal, ALUSrcB, ALUOp,
           PCSource, state, retired
  );

  modport slave (
    input  Op, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegDst,
           RegWrite, ALUSrcA, Branch, BranchNE, illegal, ALUSrcB, ALUOp,
           PCSource, state, retired
  );
endinterface

// File: rtl/uni_ctrl_mc.sv
// Multicycle MIPS-style main controller: Moore FSM with registered control
// outputs, an opcode latched in DECODE, and a retired-instruction counter.
// Optional feature: define UNI_CTRL_MC_JUMP_EN to add the JUMP state (Op 000010);
// without it that opcode is flagged illegal and state 9 falls back to FETCH.
module uni_ctrl_mc #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  uni_ctrl_mc_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } stateT;

  // Moore control word; fetchStb marks FETCH so IRWrite/PCWrite can be
  // qualified by mem_ready without registering the handshake.
  typedef struct packed {
    logic               pcWrite;
    logic               iorD;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic               regDst;
    logic               regWrite;
    logic               aluSrcA;
    logic               branch;
    logic               branchNe;
    logic               fetchStb;
    logic [1:0]         aluSrcB;
    logic [ALUOP_W-1:0] aluOp;
    logic [1:0]         pcSource;
  } ctrlT;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_BGTZ  = OP_W'(6'b000111);
`ifdef UNI_CTRL_MC_JUMP_EN
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_GTZ   = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b111);

  // Control word for a given state; op is the opcode held from DECODE.
  function automatic ctrlT decodeCtrl(input stateT st, input logic [OP_W-1:0] op);
    ctrlT c;
    c = '0;
    case (st)
      FETCH: begin
        c.memRead  = 1'b1;
        c.fetchStb = 1'b1;
        c.aluSrcB  = 2'b01;
        c.aluOp    = ALU_ADD;
      end
      DECODE: begin
        c.aluSrcB = 2'b11;
        c.aluOp   = ALU_ADD;
      end
      MEMADR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluOp   = ALU_ADD;
      end
      MEMRD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      MEMWR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      MEMWB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
      end
      EXEC: begin
        c.aluSrcA = 1'b1;
        if (op == OP_RTYPE) begin
          c.aluSrcB = 2'b00;
          c.aluOp   = ALU_FUNCT;
        end else begin
          c.aluSrcB = 2'b10;
          case (op)
            OP_ANDI: c.aluOp = ALU_AND;
            OP_ORI:  c.aluOp = ALU_OR;
            OP_SLTI: c.aluOp = ALU_SLT;
            default: c.aluOp = ALU_ADD;
          endcase
        end
      end
      ALUWB: begin
        c.regWrite = 1'b1;
        c.regDst   = (op == OP_RTYPE);
      end
      BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = 2'b00;
        c.pcSource = 2'b01;
        c.branch   = 1'b1;
        case (op)
          OP_BNE: begin
            c.aluOp    = ALU_SUB;
            c.branchNe = 1'b1;
          end
          OP_BGTZ: c.aluOp = ALU_GTZ;
          default: c.aluOp = ALU_SUB;
        endcase
      end
`ifdef UNI_CTRL_MC_JUMP_EN
      JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 2'b10;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  stateT             state;
  stateT             nextState;
  logic [OP_W-1:0]   opHeld;
  logic [OP_W-1:0]   opHeldNext;
  logic [CNT_W-1:0]  retired;
  logic              retireNow;
  ctrlT              ctrlR;
  ctrlT              ctrlOut;

  // Next-state decode; the live opcode is only consulted in DECODE.
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:  nextState = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW:                                nextState = MEMADR;
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nextState = EXEC;
          OP_BEQ, OP_BNE, OP_BGTZ:                     nextState = BRANCH;
`ifdef UNI_CTRL_MC_JUMP_EN
          OP_J:                                        nextState = JUMP;
`endif
          default:                                     nextState = FETCH;
        endcase
      end
      MEMADR: begin
        if (opHeld == OP_LW)      nextState = MEMRD;
        else if (opHeld == OP_SW) nextState = MEMWR;
        else                      nextState = FETCH;
      end
      MEMRD:  nextState = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  nextState = bus.mem_ready ? FETCH : MEMWR;
      MEMWB:  nextState = FETCH;
      EXEC:   nextState = ALUWB;
      ALUWB:  nextState = FETCH;
      BRANCH: nextState = FETCH;
`ifdef UNI_CTRL_MC_JUMP_EN
      JUMP:   nextState = FETCH;
`endif
      default: nextState = FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retireNow = 1'b0;
    case (state)
      MEMWB, ALUWB, BRANCH: retireNow = 1'b1;
      MEMWR:                retireNow = bus.mem_ready;
`ifdef UNI_CTRL_MC_JUMP_EN
      JUMP:                 retireNow = 1'b1;
`endif
      default:              retireNow = 1'b0;
    endcase
  end

  assign opHeldNext = (state == DECODE) ? bus.Op : opHeld;

  // State, held opcode, retire count and the control word for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      opHeld  <= '0;
      retired <= '0;
      ctrlR   <= decodeCtrl(FETCH, '0);
    end else begin
      state  <= nextState;
      opHeld <= opHeldNext;
      if (retireNow) retired <= retired + CNT_W'(1);
      ctrlR  <= decodeCtrl(nextState, opHeldNext);
    end
  end

  // While reset is high the outputs show the FETCH word with no write strobes.
  always_comb begin
    ctrlOut = reset ? decodeCtrl(FETCH, '0) : ctrlR;
  end

  assign bus.PCWrite  = (ctrlOut.pcWrite | (ctrlOut.fetchStb & bus.mem_ready)) & ~reset;
  assign bus.IRWrite  = ctrlOut.fetchStb & bus.mem_ready & ~reset;
  assign bus.IorD     = ctrlOut.iorD;
  assign bus.MemRead  = ctrlOut.memRead;
  assign bus.MemWrite = ctrlOut.memWrite;
  assign bus.MemToReg = ctrlOut.memToReg;
  assign bus.RegDst   = ctrlOut.regDst;
  assign bus.RegWrite = ctrlOut.regWrite;
  assign bus.ALUSrcA  = ctrlOut.aluSrcA;
  assign bus.Branch   = ctrlOut.branch;
  assign bus.BranchNE = ctrlOut.branchNe;
  assign bus.ALUSrcB  = ctrlOut.aluSrcB;
  assign bus.ALUOp    = ctrlOut.aluOp;
  assign bus.PCSource = ctrlOut.pcSource;
  assign bus.illegal  = (state == DECODE) && (nextState == FETCH) && !reset;
  assign bus.state    = state;
  assign bus.retired  = retired;

endmodule
